fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
- Multi-cycle IEEE754 single-precision divider: result = A / B.
- Inverse-operation companion to the FloatingMultiplication block, with the same A/B/result operand convention.
- Radix-2 restoring mantissa division, one quotient bit per clock, with start/done handshake.
- Used where the datapath needs quotients of multiplier outputs (scaling, normalisation).

Parameters:
- XLEN, 32, operand/result width; only 32 supported (1-8-23 format).
- QBITS, 26, quotient bits produced: 24 mantissa + guard + round; sticky taken from final remainder.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  XLEN  dividend, IEEE754 single
- B  input  XLEN  divisor, IEEE754 single
- busy  output  1  high from accepting edge until DONE state exits
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  quotient; holds until next accepted start

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE; busy=0, done=0, result=0. Applies mid-operation; the in-flight division is discarded and done is not pulsed.
- FSM: IDLE -> LOAD -> DIV -> ROUND -> DONE -> IDLE.
- IDLE: start=1 at edge t0 latches A, B, enters LOAD, busy=1.
- start while busy is ignored. Operand changes after t0 have no effect.
- LOAD (1 cycle):
  - Unpack; sign = A[31]^B[31].
  - Denormal inputs are flushed to zero.
  - Classify special cases.
  - mA={1,fracA}, mB={1,fracB}; exp = eA - eB + 127 (10-bit signed).
  - If mA<mB: dividend = mA<<1, exp-1.
- DIV (QBITS=26 cycles, counter 25..0):
  - Trial-subtract divisor from partial remainder.
  - Quotient bit = no borrow; remainder restored on borrow; remainder shifted left.
- ROUND (1 cycle): round-to-nearest-even on q[25:2] using guard q[1], round q[0] and sticky (remainder != 0).
  - Mantissa carry-out increments exp and zeroes the fraction.
  - Overflow: exp >= 255 -> signed infinity.
  - Underflow: exp <= 0 -> signed zero, flush-to-zero with no denormal output.
- Special cases: decided in LOAD; DIV is still traversed so latency stays fixed.
  - Any NaN input -> 0x7FC00000.
  - 0/0 or inf/inf -> 0x7FC00000.
  - nonzero/0 -> signed inf.
  - 0/nonzero -> signed zero.
  - inf/finite -> signed inf.
  - finite/inf -> signed zero.
- DONE (1 cycle): done=1, busy=1. result is updated on the edge entering DONE. Returns to IDLE next edge; start is accepted from then on.
- Latency:
  - done is high in the cycle after edge t0+28.
  - The next start can be accepted at edge t0+30 at the earliest.
  - Throughput is one division per 30 cycles.

Optional Feature:
- Macro FP_DIV_FLAGS_EN.
- Defined: adds output flags [4:0] = {invalid, div_by_zero, overflow, underflow, inexact}.
  - Flags are updated together with result and held until the next DONE; reset value 0.
  - inexact = guard|round|sticky, or overflow/underflow.
  - div_by_zero only for finite nonzero / 0.
  - invalid for 0/0, inf/inf, or signalling NaN input.
- Undefined: port absent; the result datapath is identical.

Test Plan:
- A=0x40C00000 (6.0), B=0x40000000 (2.0), start at t0 -> result=0x40400000 (3.0), done single pulse after edge t0+28, busy low after edge t0+29.
- A=0x3F800000 (1.0), B=0x40400000 (3.0) -> 0x3EAAAAAB (round up). A=0xC04CCCCD (-3.2), B=0xBF000000 (-0.5) -> 0x40CCCCCD (6.4).
- Specials:
  - A=0x3F800000, B=0x00000000 -> 0x7F800000 (div_by_zero=1 if FP_DIV_FLAGS_EN).
  - A=0x00000000, B=0x00000000 -> 0x7FC00000 (invalid=1).
  - A=0x80000000, B=0x40000000 -> 0x80000000.
- Range: A=0x7F000000, B=0x3E800000 -> 0x7F800000 (overflow). A=0x00800000, B=0x40000000 -> 0x00000000 (underflow flush).
- Handshake: start with 6.0/2.0, then pulse start with 1.0/3.0 at t0+5 -> ignored, result 0x40400000, only one done pulse. Back-to-back start held high -> second accepted at t0+30.
- Reset: assert rst_n=0 at t0+10 for 1 cycle -> busy=0, result=0, no done. Fresh start after release completes normally with the standard 28-edge latency.

Source files
------------

// File: rtl/fp_div_iter.sv
// fp_div_iter: multi-cycle IEEE754 single-precision divider (result = A / B).
// Radix-2 restoring mantissa division, one quotient bit per clock, with
// round-to-nearest-even and flush-to-zero on denormal inputs and outputs.
// Optional macro FP_DIV_FLAGS_EN adds the flags output
// {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div_iter #(
  parameter int XLEN  = 32,
  parameter int QBITS = 26
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
`ifdef FP_DIV_FLAGS_EN
  output logic [4:0]      flags,
`endif
  output logic [XLEN-1:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]  a_q, b_q;
  logic             sign_q;
  logic signed [9:0] exp_q;
  logic [25:0]      rem_q;
  logic [23:0]      dvs_q;
  logic [QBITS-1:0] quo_q;
  logic [4:0]       cnt_q;
  logic             special_q;
  logic [31:0]      special_val_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] ma, mb;
  logic        shift;
  logic        sign_ld;
  logic signed [9:0] exp_ld;
  logic [25:0] rem_ld;
  logic        sp_ld;
  logic [31:0] sp_val_ld;

  logic [26:0] trial;
  logic        no_borrow;
  logic [25:0] rem_base, rem_step;

  logic        guard, rnd, sticky, rup;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic signed [9:0] exp_r;
  logic        ovf, unf;
  logic [31:0] res_nxt;

`ifdef FP_DIV_FLAGS_EN
  logic       invalid_q, dbz_q;
  logic       invalid_ld, dbz_ld;
  logic [4:0] flags_nxt;
`endif

  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign fa = a_q[22:0];
  assign fb = b_q[22:0];

  // State register; reset discards any in-flight division.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD:  state_nxt = DIV;
      DIV:   if (cnt_q == 5'd0) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Unpack operands, classify special cases and pre-align the dividend.
  always_comb begin
    sign_ld   = a_q[31] ^ b_q[31];
    a_zero    = (ea == 8'd0);
    b_zero    = (eb == 8'd0);
    a_inf     = (ea == 8'hFF) && (fa == 23'd0);
    b_inf     = (eb == 8'hFF) && (fb == 23'd0);
    a_nan     = (ea == 8'hFF) && (fa != 23'd0);
    b_nan     = (eb == 8'hFF) && (fb != 23'd0);
    ma        = {1'b1, fa};
    mb        = {1'b1, fb};
    shift     = (ma < mb);
    exp_ld    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
              - $signed({9'd0, shift});
    rem_ld    = shift ? {1'b0, ma, 1'b0} : {2'b00, ma};
    sp_ld     = 1'b1;
    sp_val_ld = 32'd0;
    if (a_nan || b_nan)                        sp_val_ld = QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) sp_val_ld = QNAN;
    else if (a_inf || b_zero)                  sp_val_ld = {sign_ld, 8'hFF, 23'd0};
    else if (a_zero || b_inf)                  sp_val_ld = {sign_ld, 31'd0};
    else                                       sp_ld = 1'b0;
`ifdef FP_DIV_FLAGS_EN
    dbz_ld     = b_zero && !a_zero && !a_inf && !a_nan;
    invalid_ld = (a_zero && b_zero) || (a_inf && b_inf)
               || (a_nan && !fa[22]) || (b_nan && !fb[22]);
`endif
  end

  // One restoring-division step: trial subtract, restore on borrow, shift.
  always_comb begin
    trial     = {1'b0, rem_q} - {3'b000, dvs_q};
    no_borrow = ~trial[26];
    rem_base  = no_borrow ? trial[25:0] : rem_q;
    rem_step  = rem_base << 1;
  end

  // Round-to-nearest-even, renormalise on carry, then range checks.
  always_comb begin
    guard   = quo_q[1];
    rnd     = quo_q[0];
    sticky  = |rem_q;
    rup     = guard & (rnd | sticky | quo_q[2]);
    mant_r  = {1'b0, quo_q[25:2]} + {24'd0, rup};
    frac_r  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_r   = exp_q + $signed({9'd0, mant_r[24]});
    ovf     = (exp_r >= 10'sd255);
    unf     = (exp_r <= 10'sd0);
    if (special_q) res_nxt = special_val_q;
    else if (ovf)  res_nxt = {sign_q, 8'hFF, 23'd0};
    else if (unf)  res_nxt = {sign_q, 31'd0};
    else           res_nxt = {sign_q, exp_r[7:0], frac_r};
`ifdef FP_DIV_FLAGS_EN
    if (special_q) flags_nxt = {invalid_q, dbz_q, 3'b000};
    else           flags_nxt = {2'b00, ovf, unf, guard | rnd | sticky | ovf | unf};
`endif
  end

  // Operand capture and iterative datapath; no reset needed, state gates it.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          a_q <= A;
          b_q <= B;
        end
      end
      LOAD: begin
        sign_q        <= sign_ld;
        exp_q         <= exp_ld;
        rem_q         <= rem_ld;
        dvs_q         <= mb;
        quo_q         <= '0;
        cnt_q         <= 5'd25;
        special_q     <= sp_ld;
        special_val_q <= sp_val_ld;
`ifdef FP_DIV_FLAGS_EN
        invalid_q     <= invalid_ld;
        dbz_q         <= dbz_ld;
`endif
      end
      DIV: begin
        rem_q <= rem_step;
        quo_q <= {quo_q[QBITS-2:0], no_borrow};
        cnt_q <= cnt_q - 5'd1;
      end
      default: ;
    endcase
  end

  // Result register, written on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
`ifdef FP_DIV_FLAGS_EN
      flags  <= '0;
`endif
    end else if (state == ROUND) begin
      result <= res_nxt;
`ifdef FP_DIV_FLAGS_EN
      flags  <= flags_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        busy, done;
  logic [31:0] result;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
`ifdef FP_DIV_FLAGS_EN
    .flags  (flags),
`endif
    .result (result)
  );

  // Launch one division at the next edge (t0), scramble operands afterwards,
  // and observe 35 edges #1 after each edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int first_done,
                         output int n_done, output int busy_low_at,
                         output logic busy0);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    busy0 = busy;
    start = 1'b0;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h1234_5678;
    first_done  = -1;
    n_done      = 0;
    busy_low_at = -1;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (!busy && busy_low_at < 0) busy_low_at = k;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("[TB] FAIL reset_result got=%h want=00000000", result); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res; int fd, nd, bl; logic b0;
    run_div(32'h40C0_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (b0 !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_t0 got=%b want=1", b0); end
    total++; if (res !== 32'h4040_0000) begin bad++; $display("[TB] FAIL basic_result got=%h want=40400000", res); end
    total++; if (fd != 28) begin bad++; $display("[TB] FAIL basic_done_edge got=%0d want=28", fd); end
    total++; if (nd != 1) begin bad++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", nd); end
    total++; if (bl != 29) begin bad++; $display("[TB] FAIL basic_busy_low got=%0d want=29", bl); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b00000) begin bad++; $display("[TB] FAIL basic_flags got=%b want=00000", flags); end
`endif
  endtask

  task automatic test_rounding();
    logic [31:0] res; int fd, nd, bl; logic b0;
    run_div(32'h3F80_0000, 32'h4040_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h3EAA_AAAB) begin bad++; $display("[TB] FAIL round_1div3 got=%h want=3EAAAAAB", res); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b00001) begin bad++; $display("[TB] FAIL round_1div3_flags got=%b want=00001", flags); end
`endif
    run_div(32'hC04C_CCCD, 32'hBF00_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h40CC_CCCD) begin bad++; $display("[TB] FAIL round_neg got=%h want=40CCCCCD", res); end
    run_div(32'h3F80_0000, 32'hC000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'hBF00_0000) begin bad++; $display("[TB] FAIL round_half got=%h want=BF000000", res); end
  endtask

  task automatic test_specials();
    logic [31:0] res; int fd, nd, bl; logic b0;
    run_div(32'h3F80_0000, 32'h0000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7F80_0000) begin bad++; $display("[TB] FAIL spec_div0 got=%h want=7F800000", res); end
    total++; if (fd != 28) begin bad++; $display("[TB] FAIL spec_latency got=%0d want=28", fd); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b01000) begin bad++; $display("[TB] FAIL spec_div0_flags got=%b want=01000", flags); end
`endif
    run_div(32'h0000_0000, 32'h0000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7FC0_0000) begin bad++; $display("[TB] FAIL spec_0div0 got=%h want=7FC00000", res); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b10000) begin bad++; $display("[TB] FAIL spec_0div0_flags got=%b want=10000", flags); end
`endif
    run_div(32'h8000_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h8000_0000) begin bad++; $display("[TB] FAIL spec_negzero got=%h want=80000000", res); end
    run_div(32'h7FC0_0001, 32'h3F80_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7FC0_0000) begin bad++; $display("[TB] FAIL spec_nan got=%h want=7FC00000", res); end
    run_div(32'h7F80_0000, 32'hFF80_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7FC0_0000) begin bad++; $display("[TB] FAIL spec_infinf got=%h want=7FC00000", res); end
    run_div(32'hFF80_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'hFF80_0000) begin bad++; $display("[TB] FAIL spec_inf_fin got=%h want=FF800000", res); end
    run_div(32'h3F80_0000, 32'hFF80_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h8000_0000) begin bad++; $display("[TB] FAIL spec_fin_inf got=%h want=80000000", res); end
    run_div(32'h0040_0000, 32'h3F80_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h0000_0000) begin bad++; $display("[TB] FAIL spec_denorm_a got=%h want=00000000", res); end
    run_div(32'h3F80_0000, 32'h0000_0001, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7F80_0000) begin bad++; $display("[TB] FAIL spec_denorm_b got=%h want=7F800000", res); end
  endtask

  task automatic test_range();
    logic [31:0] res; int fd, nd, bl; logic b0;
    run_div(32'h7F00_0000, 32'h3E80_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h7F80_0000) begin bad++; $display("[TB] FAIL range_overflow got=%h want=7F800000", res); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b00101) begin bad++; $display("[TB] FAIL range_overflow_flags got=%b want=00101", flags); end
`endif
    run_div(32'h0080_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h0000_0000) begin bad++; $display("[TB] FAIL range_underflow got=%h want=00000000", res); end
`ifdef FP_DIV_FLAGS_EN
    total++; if (flags !== 5'b00011) begin bad++; $display("[TB] FAIL range_underflow_flags got=%b want=00011", flags); end
`endif
    run_div(32'h0100_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h0080_0000) begin bad++; $display("[TB] FAIL range_min_normal got=%h want=00800000", res); end
  endtask

  task automatic test_ignore_start();
    int fd = -1;
    int nd = 0;
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 32'h3F80_0000;
    b_in  = 32'h4040_0000;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (done) begin
        nd++;
        if (fd < 0) fd = k;
      end
    end
    total++; if (result !== 32'h4040_0000) begin bad++; $display("[TB] FAIL ignore_result got=%h want=40400000", result); end
    total++; if (nd != 1) begin bad++; $display("[TB] FAIL ignore_pulses got=%0d want=1", nd); end
    total++; if (fd != 28) begin bad++; $display("[TB] FAIL ignore_done_edge got=%0d want=28", fd); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int nd = 0;
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 62; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        a_in = 32'h3F80_0000;
        b_in = 32'h4040_0000;
      end
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 29) begin
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_gap got=%b want=0", busy); end
        total++; if (result !== 32'h4040_0000) begin bad++; $display("[TB] FAIL b2b_first_result got=%h want=40400000", result); end
      end
      if (k == 30) begin
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_accept got=%b want=1", busy); end
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (nd != 2) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d want=2", nd); end
    total++; if (d1 != 28) begin bad++; $display("[TB] FAIL b2b_first_done got=%0d want=28", d1); end
    total++; if (d2 != 58) begin bad++; $display("[TB] FAIL b2b_second_done got=%0d want=58", d2); end
    total++; if (result !== 32'h3EAA_AAAB) begin bad++; $display("[TB] FAIL b2b_second_result got=%h want=3EAAAAAB", result); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int fd, nd, bl; logic b0;
    int stray = 0;
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
    total++; if (result !== 32'd0) begin bad++; $display("[TB] FAIL midreset_result got=%h want=00000000", result); end
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (done) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("[TB] FAIL midreset_no_done got=%0d want=0", stray); end
    run_div(32'h40C0_0000, 32'h4000_0000, res, fd, nd, bl, b0);
    total++; if (res !== 32'h4040_0000) begin bad++; $display("[TB] FAIL midreset_fresh_result got=%h want=40400000", res); end
    total++; if (fd != 28) begin bad++; $display("[TB] FAIL midreset_fresh_latency got=%0d want=28", fd); end
    total++; if (nd != 1) begin bad++; $display("[TB] FAIL midreset_fresh_pulses got=%0d want=1", nd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_range();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
